gelato_simt_stack: RTL and testbench

Parametrised per-warp SIMT reconvergence stack and the successor to the single-entry split table. It keeps a DEPTH-entry stack of {pc, thread mask, reconvergence pc} for each of WARP_NUM warps. Its per-warp top-of-stack drives the fetch scheduler. Decode writes into it once per cycle: advance, divergent branch, launch and kill. Pushes on divergence and pops at the reconvergence pc are automatic.

---
 rtl/gelato_simt_stack.sv | 144 ++++++++++++++
 tb/tb_gelato_simt_stack.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/gelato_simt_stack.sv
// Per-warp SIMT reconvergence stack: top-of-stack feeds fetch, decode updates one warp per cycle.
// Divergent branches push the not-taken and taken paths; reaching the reconvergence pc pops.
module gelato_simt_stack #(
   parameter int WARP_NUM   = 4,
   parameter int THREAD_NUM = 32,
   parameter int PC_WIDTH   = 32,
   parameter int DEPTH      = 8,
   localparam int WW = (WARP_NUM > 1) ? $clog2(WARP_NUM) : 1,
   localparam int DW = $clog2(DEPTH + 1),
   localparam int IW = $clog2(DEPTH)
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  rdy,
   output logic [WARP_NUM-1:0]                   sel_valid,
   output logic [WARP_NUM-1:0][PC_WIDTH-1:0]     sel_pc,
   output logic [WARP_NUM-1:0][THREAD_NUM-1:0]   sel_mask,
   output logic [WARP_NUM-1:0][DW-1:0]           sel_depth,
   input  logic                                  upd_valid,
   input  logic [WW-1:0]                         upd_warp,
   input  logic [2:0]                            upd_op,
   input  logic [PC_WIDTH-1:0]                   upd_pc,
   input  logic [PC_WIDTH-1:0]                   upd_taken_pc,
   input  logic [THREAD_NUM-1:0]                 upd_taken_mask,
   input  logic [PC_WIDTH-1:0]                   upd_rpc,
   output logic [THREAD_NUM-1:0]                 upd_mask,
   output logic                                  ovf_pulse,
   output logic [WW-1:0]                         ovf_warp
);

   localparam logic [2:0] OP_ADVANCE = 3'd1;
   localparam logic [2:0] OP_BRANCH  = 3'd2;
   localparam logic [2:0] OP_LAUNCH  = 3'd3;
   localparam logic [2:0] OP_KILL    = 3'd4;

   logic [DEPTH-1:0][PC_WIDTH-1:0]   pc_q   [WARP_NUM];
   logic [DEPTH-1:0][THREAD_NUM-1:0] mask_q [WARP_NUM];
   logic [DEPTH-1:0][PC_WIDTH-1:0]   rpc_q  [WARP_NUM];
   logic [DW-1:0]                    depth_q[WARP_NUM];

   logic                  in_range, act, launched, adv;
   logic [DW-1:0]         cur_depth;
   logic [IW-1:0]         sp, sp1, sp2;
   logic [PC_WIDTH-1:0]   top_pc, top_rpc, next_pc;
   logic [THREAD_NUM-1:0] top_mask, t_mask, n_mask;
   logic                  do_launch, do_kill, do_set_pc, do_pop, do_push, ovf_req;

   // Top-of-stack view per warp; a warp with no entries shows all zeros.
   always_comb begin
      for (int i = 0; i < WARP_NUM; i++) begin
         sel_depth[i] = depth_q[i];
         sel_pc[i]    = '0;
         sel_mask[i]  = '0;
         if (depth_q[i] != '0) begin
            sel_pc[i]   = pc_q[i][IW'(depth_q[i] - DW'(1))];
            sel_mask[i] = mask_q[i][IW'(depth_q[i] - DW'(1))];
         end
         sel_valid[i] = (depth_q[i] != '0) && (sel_mask[i] != '0);
      end
   end

   // Decode the requested op against the target warp's current top entry.
   always_comb begin
      in_range  = 32'(upd_warp) < 32'(WARP_NUM);
      act       = upd_valid && rdy && in_range;
      cur_depth = in_range ? depth_q[upd_warp] : '0;
      launched  = cur_depth != '0;
      sp        = IW'(cur_depth - DW'(1));
      sp1       = sp + IW'(1);
      sp2       = sp + IW'(2);
      top_pc    = pc_q[upd_warp][sp];
      top_mask  = mask_q[upd_warp][sp];
      top_rpc   = rpc_q[upd_warp][sp];
      upd_mask  = in_range ? sel_mask[upd_warp] : '0;
      t_mask    = upd_taken_mask & top_mask;
      n_mask    = top_mask & ~t_mask;
      next_pc   = upd_pc;
      adv       = 1'b0;
      do_launch = 1'b0;
      do_kill   = 1'b0;
      do_push   = 1'b0;
      ovf_req   = 1'b0;
      case (upd_op)
         OP_LAUNCH:  do_launch = act;
         OP_KILL:    do_kill   = act && launched;
         OP_ADVANCE: adv       = act && launched;
         OP_BRANCH: begin
            if (act && launched) begin
               if (t_mask == '0) begin
                  adv = 1'b1;
               end else if (n_mask == '0) begin
                  adv     = 1'b1;
                  next_pc = upd_taken_pc;
               end else if (32'(cur_depth) + 32'd2 <= 32'(DEPTH)) begin
                  do_push = 1'b1;
               end else begin
                  ovf_req = 1'b1;
               end
            end
         end
         default: ;
      endcase
      // Only a single pop per update; the base entry can never pop.
      do_pop    = adv && (cur_depth > DW'(1)) && (next_pc == top_rpc);
      do_set_pc = adv && !do_pop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WARP_NUM; i++) begin
            pc_q[i]    <= '0;
            mask_q[i]  <= '0;
            rpc_q[i]   <= '0;
            depth_q[i] <= '0;
         end
         ovf_pulse <= 1'b0;
         ovf_warp  <= '0;
      end else begin
         ovf_pulse <= ovf_req;
         if (ovf_req) ovf_warp <= upd_warp;
         if (do_launch) begin
            pc_q[upd_warp][0]   <= upd_pc;
            mask_q[upd_warp][0] <= upd_taken_mask;
            rpc_q[upd_warp][0]  <= '1;
            depth_q[upd_warp]   <= DW'(1);
         end
         if (do_kill)   depth_q[upd_warp]  <= '0;
         if (do_set_pc) pc_q[upd_warp][sp] <= next_pc;
         if (do_pop)    depth_q[upd_warp]  <= cur_depth - DW'(1);
         // Old top becomes the reconvergence point; taken path ends up on top.
         if (do_push) begin
            pc_q[upd_warp][sp]    <= upd_rpc;
            pc_q[upd_warp][sp1]   <= upd_pc;
            mask_q[upd_warp][sp1] <= n_mask;
            rpc_q[upd_warp][sp1]  <= upd_rpc;
            pc_q[upd_warp][sp2]   <= upd_taken_pc;
            mask_q[upd_warp][sp2] <= t_mask;
            rpc_q[upd_warp][sp2]  <= upd_rpc;
            depth_q[upd_warp]     <= cur_depth + DW'(2);
         end
      end
   end

endmodule

// File: tb/tb_gelato_simt_stack.sv
// Directed bench for gelato_simt_stack: a vector table plus hand sequences for overflow and reset.
// A second, shallow instance shares the stimulus to reach the overflow corner.
module tb_gelato_simt_stack;

   logic clk = 1'b0;
   logic rst, rdy, upd_valid;
   logic [1:0]  upd_warp;
   logic [2:0]  upd_op;
   logic [31:0] upd_pc, upd_taken_pc, upd_taken_mask, upd_rpc;

   logic [3:0]        sel_valid, s_sel_valid;
   logic [3:0][31:0]  sel_pc, sel_mask, s_sel_pc, s_sel_mask;
   logic [3:0][3:0]   sel_depth;
   logic [3:0][1:0]   s_sel_depth;
   logic [31:0]       upd_mask, s_upd_mask;
   logic              ovf_pulse, s_ovf_pulse;
   logic [1:0]        ovf_warp, s_ovf_warp;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   gelato_simt_stack #(.WARP_NUM(4), .THREAD_NUM(32), .PC_WIDTH(32), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .sel_valid(sel_valid), .sel_pc(sel_pc), .sel_mask(sel_mask), .sel_depth(sel_depth),
      .upd_valid(upd_valid), .upd_warp(upd_warp), .upd_op(upd_op), .upd_pc(upd_pc),
      .upd_taken_pc(upd_taken_pc), .upd_taken_mask(upd_taken_mask), .upd_rpc(upd_rpc),
      .upd_mask(upd_mask), .ovf_pulse(ovf_pulse), .ovf_warp(ovf_warp));

   gelato_simt_stack #(.WARP_NUM(4), .THREAD_NUM(32), .PC_WIDTH(32), .DEPTH(3)) dut_small (
      .clk(clk), .rst(rst), .rdy(rdy),
      .sel_valid(s_sel_valid), .sel_pc(s_sel_pc), .sel_mask(s_sel_mask), .sel_depth(s_sel_depth),
      .upd_valid(upd_valid), .upd_warp(upd_warp), .upd_op(upd_op), .upd_pc(upd_pc),
      .upd_taken_pc(upd_taken_pc), .upd_taken_mask(upd_taken_mask), .upd_rpc(upd_rpc),
      .upd_mask(s_upd_mask), .ovf_pulse(s_ovf_pulse), .ovf_warp(s_ovf_warp));

   typedef struct {
      logic        rdy;
      logic        valid;
      logic [1:0]  warp;
      logic [2:0]  op;
      logic [31:0] pc, tpc, tmask, rpc;
      logic [1:0]  chk;
      logic [3:0]  ev;
      logic [31:0] epc, emask;
      logic [3:0]  ed;
   } vec_t;

   vec_t vecs[21];

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive at the falling edge, then return just after the next rising edge.
   task automatic apply_stimulus(input logic r, input logic v, input logic [1:0] w, input logic [2:0] op,
                                 input logic [31:0] pc, input logic [31:0] tpc,
                                 input logic [31:0] tm, input logic [31:0] rp);
      @(negedge clk);
      rdy = r; upd_valid = v; upd_warp = w; upd_op = op;
      upd_pc = pc; upd_taken_pc = tpc; upd_taken_mask = tm; upd_rpc = rp;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; upd_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; upd_valid = 1'b0; upd_warp = '0; upd_op = '0;
      upd_pc = '0; upd_taken_pc = '0; upd_taken_mask = '0; upd_rpc = '0;

      //          rdy   vld  warp op  pc            tpc       tmask         rpc       chk  ev       epc           emask         ed
      vecs[0]  = '{1'b1,1'b1,2'd0,3'd3,32'h100,     32'h0,    32'hFFFFFFFF,32'h0,    2'd0,4'b0001,32'h100,     32'hFFFFFFFF,4'd1};
      vecs[1]  = '{1'b1,1'b1,2'd0,3'd2,32'h104,     32'h200,  32'h0000FFFF,32'h300,  2'd0,4'b0001,32'h200,     32'h0000FFFF,4'd3};
      vecs[2]  = '{1'b1,1'b1,2'd0,3'd1,32'h204,     32'h0,    32'h0,       32'h0,    2'd0,4'b0001,32'h204,     32'h0000FFFF,4'd3};
      vecs[3]  = '{1'b1,1'b1,2'd0,3'd1,32'h300,     32'h0,    32'h0,       32'h0,    2'd0,4'b0001,32'h104,     32'hFFFF0000,4'd2};
      vecs[4]  = '{1'b1,1'b1,2'd0,3'd1,32'h300,     32'h0,    32'h0,       32'h0,    2'd0,4'b0001,32'h300,     32'hFFFFFFFF,4'd1};
      vecs[5]  = '{1'b1,1'b1,2'd0,3'd1,32'hFFFFFFFF,32'h0,    32'h0,       32'h0,    2'd0,4'b0001,32'hFFFFFFFF,32'hFFFFFFFF,4'd1};
      vecs[6]  = '{1'b1,1'b1,2'd0,3'd2,32'h308,     32'h400,  32'h0,       32'h500,  2'd0,4'b0001,32'h308,     32'hFFFFFFFF,4'd1};
      vecs[7]  = '{1'b1,1'b1,2'd0,3'd2,32'h30C,     32'h400,  32'hFFFFFFFF,32'h500,  2'd0,4'b0001,32'h400,     32'hFFFFFFFF,4'd1};
      vecs[8]  = '{1'b1,1'b1,2'd1,3'd3,32'h800,     32'h0,    32'hF,       32'h0,    2'd1,4'b0011,32'h800,     32'hF,       4'd1};
      vecs[9]  = '{1'b1,1'b1,2'd1,3'd2,32'h804,     32'h900,  32'hF3,      32'hA00,  2'd1,4'b0011,32'h900,     32'h3,       4'd3};
      vecs[10] = '{1'b1,1'b1,2'd1,3'd2,32'h904,     32'hA00,  32'hFF,      32'hA00,  2'd1,4'b0011,32'h804,     32'hC,       4'd2};
      vecs[11] = '{1'b0,1'b1,2'd1,3'd1,32'h999,     32'h0,    32'h0,       32'h0,    2'd1,4'b0011,32'h804,     32'hC,       4'd2};
      vecs[12] = '{1'b1,1'b1,2'd1,3'd0,32'h999,     32'h0,    32'h0,       32'h0,    2'd1,4'b0011,32'h804,     32'hC,       4'd2};
      vecs[13] = '{1'b1,1'b1,2'd1,3'd6,32'h999,     32'h0,    32'h0,       32'h0,    2'd1,4'b0011,32'h804,     32'hC,       4'd2};
      vecs[14] = '{1'b1,1'b1,2'd1,3'd2,32'h808,     32'h880,  32'h4,       32'h8A0,  2'd1,4'b0011,32'h880,     32'h4,       4'd4};
      vecs[15] = '{1'b1,1'b1,2'd1,3'd1,32'h8A0,     32'h0,    32'h0,       32'h0,    2'd1,4'b0011,32'h808,     32'h8,       4'd3};
      vecs[16] = '{1'b1,1'b1,2'd1,3'd1,32'h8A0,     32'h0,    32'h0,       32'h0,    2'd1,4'b0011,32'h8A0,     32'hC,       4'd2};
      vecs[17] = '{1'b1,1'b1,2'd1,3'd1,32'hA00,     32'h0,    32'h0,       32'h0,    2'd1,4'b0011,32'hA00,     32'hF,       4'd1};
      vecs[18] = '{1'b1,1'b1,2'd0,3'd4,32'h0,       32'h0,    32'h0,       32'h0,    2'd0,4'b0010,32'h0,       32'h0,       4'd0};
      vecs[19] = '{1'b1,1'b1,2'd0,3'd1,32'h123,     32'h0,    32'h0,       32'h0,    2'd0,4'b0010,32'h0,       32'h0,       4'd0};
      vecs[20] = '{1'b1,1'b1,2'd2,3'd3,32'h40,      32'h0,    32'h0,       32'h0,    2'd2,4'b0010,32'h40,      32'h0,       4'd1};

      do_reset();
      check_output("reset sel_valid", 64'(sel_valid), 64'h0);
      check_output("reset sel_depth", 64'(sel_depth), 64'h0);
      check_output("reset sel_pc", 64'(sel_pc[0]), 64'h0);
      check_output("reset ovf_pulse", 64'(ovf_pulse), 64'h0);

      for (int i = 0; i < 21; i++) begin
         apply_stimulus(vecs[i].rdy, vecs[i].valid, vecs[i].warp, vecs[i].op,
                        vecs[i].pc, vecs[i].tpc, vecs[i].tmask, vecs[i].rpc);
         check_output($sformatf("row%0d sel_valid", i), 64'(sel_valid), 64'(vecs[i].ev));
         check_output($sformatf("row%0d sel_pc", i), 64'(sel_pc[vecs[i].chk]), 64'(vecs[i].epc));
         check_output($sformatf("row%0d sel_mask", i), 64'(sel_mask[vecs[i].chk]), 64'(vecs[i].emask));
         check_output($sformatf("row%0d sel_depth", i), 64'(sel_depth[vecs[i].chk]), 64'(vecs[i].ed));
         check_output($sformatf("row%0d ovf_pulse", i), 64'(ovf_pulse), 64'h0);
      end

      // Overflow on the shallow instance while the deep one keeps pushing.
      do_reset();
      apply_stimulus(1'b1, 1'b1, 2'd0, 3'd3, 32'h100, 32'h0, 32'hFFFFFFFF, 32'h0);
      apply_stimulus(1'b1, 1'b1, 2'd0, 3'd2, 32'h104, 32'h200, 32'h0000FFFF, 32'h300);
      check_output("small depth after split", 64'(s_sel_depth[0]), 64'd3);
      check_output("small ovf after split", 64'(s_ovf_pulse), 64'h0);
      @(negedge clk);
      upd_op = 3'd2; upd_pc = 32'h204; upd_taken_pc = 32'h280; upd_taken_mask = 32'hFF; upd_rpc = 32'h2F0;
      #1;
      check_output("upd_mask registered top", 64'(upd_mask), 64'h0000FFFF);
      @(posedge clk);
      #1;
      check_output("small ovf_pulse", 64'(s_ovf_pulse), 64'h1);
      check_output("small ovf_warp", 64'(s_ovf_warp), 64'h0);
      check_output("small depth held", 64'(s_sel_depth[0]), 64'd3);
      check_output("small pc held", 64'(s_sel_pc[0]), 64'h200);
      check_output("small mask held", 64'(s_sel_mask[0]), 64'h0000FFFF);
      check_output("deep nested depth", 64'(sel_depth[0]), 64'd5);
      check_output("deep nested pc", 64'(sel_pc[0]), 64'h280);
      check_output("deep nested mask", 64'(sel_mask[0]), 64'hFF);
      apply_stimulus(1'b1, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      check_output("small ovf one cycle", 64'(s_ovf_pulse), 64'h0);

      apply_stimulus(1'b1, 1'b1, 2'd3, 3'd3, 32'h0, 32'h0, 32'hF, 32'h0);
      apply_stimulus(1'b1, 1'b1, 2'd3, 3'd2, 32'h4, 32'h10, 32'h3, 32'h20);
      apply_stimulus(1'b1, 1'b1, 2'd3, 3'd2, 32'h14, 32'h18, 32'h1, 32'h1C);
      check_output("small ovf w3 pulse", 64'(s_ovf_pulse), 64'h1);
      check_output("small ovf w3 warp", 64'(s_ovf_warp), 64'h3);
      apply_stimulus(1'b0, 1'b1, 2'd3, 3'd2, 32'h14, 32'h18, 32'h1, 32'h1C);
      check_output("rdy low ovf_pulse", 64'(s_ovf_pulse), 64'h0);
      check_output("rdy low ovf_warp", 64'(s_ovf_warp), 64'h3);

      // Reset with a concurrent divergent branch while w0 sits at depth 5.
      @(negedge clk);
      rst = 1'b1; rdy = 1'b1; upd_valid = 1'b1; upd_warp = 2'd0; upd_op = 3'd2;
      upd_pc = 32'h284; upd_taken_pc = 32'h290; upd_taken_mask = 32'h0F; upd_rpc = 32'h2A0;
      @(posedge clk);
      #1;
      rst = 1'b0; upd_valid = 1'b0;
      check_output("mid reset depth", 64'(sel_depth), 64'h0);
      check_output("mid reset valid", 64'(sel_valid), 64'h0);
      check_output("mid reset ovf", 64'(ovf_pulse), 64'h0);
      check_output("mid reset small ovf_warp", 64'(s_ovf_warp), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
